// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch slice: NOP encoding,
// fetch FSM state type and the default reset PC.
package rv_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: kill (flush/redirect) beats stall, stall beats load;
// anything else inserts a NOP bubble.
module if_id_reg
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        kill,
    input  logic        load,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        valid_D
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_D <= NOP;
            pc_D    <= '0;
            pc4_D   <= '0;
            valid_D <= 1'b0;
        end else if (kill) begin
            instr_D <= NOP;
            valid_D <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr_D <= instr;
                pc_D    <= pc;
                pc4_D   <= pc + 32'd4;
                valid_D <= 1'b1;
            end else begin
                instr_D <= NOP;
                valid_D <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch FSM (FETCH/HOLD/DRAIN), hold buffer, IF/ID.
// Optional performance counters enabled by defining IF_PERF_CNT_EN.
module if_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc4_D,
    output logic        valid_D,
    output logic [6:0]  opcode_D,
    output logic [2:0]  func3_D,
    output logic        func7_5_D
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    fetch_state_t state, state_nxt;

    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic        kill;
    logic        load;
    logic [31:0] load_instr;
    logic [31:0] load_pc;
    logic        advance;
    logic        capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (br_taken)
                    state_nxt = imem_valid ? FETCH : DRAIN;
                else if (imem_valid && stall)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (br_taken || (!stall && !flush))
                    state_nxt = FETCH;
            end
            DRAIN: begin
                if (imem_valid)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req   = (state != HOLD);
        imem_addr  = (state == DRAIN) ? drain_addr : pc;
        kill       = flush | br_taken;
        load       = 1'b0;
        load_instr = imem_rdata;
        load_pc    = pc;
        case (state)
            FETCH: load = imem_valid;
            HOLD: begin
                load       = 1'b1;
                load_instr = buf_instr;
                load_pc    = buf_pc;
            end
            default: load = 1'b0;
        endcase
        advance = load && !kill && !stall;
        capture = (state == FETCH) && imem_valid && stall && !br_taken;
    end

    // drain_addr keeps the abandoned request address stable while the
    // redirected PC waits for the stale response to come back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            drain_addr <= '0;
            buf_instr  <= '0;
            buf_pc     <= '0;
        end else begin
            if (br_taken)
                pc <= br_target & ~32'd1;
            else if (advance)
                pc <= pc + 32'd4;
            if ((state == FETCH) && br_taken)
                drain_addr <= pc;
            if (capture) begin
                buf_instr <= imem_rdata;
                buf_pc    <= pc;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .kill    (kill),
        .load    (load),
        .instr   (load_instr),
        .pc      (load_pc),
        .instr_D (instr_D),
        .pc_D    (pc_D),
        .pc4_D   (pc4_D),
        .valid_D (valid_D)
    );

    assign opcode_D  = instr_D[6:0];
    assign func3_D   = instr_D[14:12];
    assign func7_5_D = instr_D[30];

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (advance)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (kill || (!stall && !load))
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with an expected-instruction queue.
// Define IF_PERF_CNT_EN to also exercise the performance counter ports.
module tb_if_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] instr_D, pc_D, pc4_D;
    logic        valid_D;
    logic [6:0]  opcode_D;
    logic [2:0]  func3_D;
    logic        func7_5_D;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt;
`endif

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .instr_D    (instr_D),
        .pc_D       (pc_D),
        .pc4_D      (pc4_D),
        .valid_D    (valid_D),
        .opcode_D   (opcode_D),
        .func3_D    (func3_D),
        .func7_5_D  (func7_5_D)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    logic [31:0] last_instr = '0;
    logic [31:0] last_pc = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a response for addr in the current cycle; optionally expect it in IF/ID.
    task automatic fetch(input logic [31:0] addr, input bit expect_it);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, addr);
        imem_valid = 1'b1;
        imem_rdata = mem(addr);
        if (expect_it) sb.push_back('{instr: mem(addr), pc: addr});
    endtask

    // mode 0: bubble expected, 1: next queued instruction, 2: IF/ID frozen
    task automatic tick(input int mode);
        exp_t e;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        br_taken   = 1'b0;
        flush      = 1'b0;
        case (mode)
            0: begin
                chk("bubble_valid", 32'(valid_D), 32'd0);
                chk("bubble_instr", instr_D, NOP);
            end
            1: begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ifid_instr", instr_D, e.instr);
                    chk("ifid_pc", pc_D, e.pc);
                    chk("ifid_pc4", pc4_D, e.pc + 32'd4);
                    chk("ifid_valid", 32'(valid_D), 32'd1);
                    chk("ifid_opcode", 32'(opcode_D), 32'(e.instr[6:0]));
                    last_instr = e.instr;
                    last_pc    = e.pc;
                end
            end
            default: begin
                chk("held_instr", instr_D, last_instr);
                chk("held_pc", pc_D, last_pc);
                chk("held_valid", 32'(valid_D), 32'd1);
            end
        endcase
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(valid_D), 32'd0);
        chk("rst_instr", instr_D, NOP);
        chk("rst_pc", pc_D, 32'd0);
        chk("rst_pc4", pc4_D, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // zero-wait streaming
        for (int i = 0; i < 6; i++) begin
            fetch(32'(4 * i), 1'b1);
            tick(1);
        end

        // response two cycles late
        repeat (2) begin
            chk("wait_addr", imem_addr, 32'd24);
            chk("wait_req", 32'(imem_req), 32'd1);
            tick(0);
        end
        fetch(32'd24, 1'b1);
        tick(1);

        // stall while the response arrives
        fetch(32'd28, 1'b0);
        stall = 1'b1;
        tick(2);
        chk("hold_req", 32'(imem_req), 32'd0);
        repeat (2) begin
            tick(2);
            chk("hold_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        sb.push_back('{instr: mem(32'd28), pc: 32'd28});
        tick(1);
        fetch(32'd32, 1'b1);
        tick(1);

        // redirect during pending fetch, stale response discarded
        chk("pre_br_addr", imem_addr, 32'd36);
        br_taken  = 1'b1;
        br_target = 32'h0000_0101;
        tick(0);
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_addr", imem_addr, 32'd36);
        tick(0);
        imem_valid = 1'b1;
        imem_rdata = mem(32'd36);
        tick(0);
        fetch(32'h0000_0100, 1'b1);
        tick(1);

        // same-cycle redirect, then PC wrap
        chk("pre_wrap_addr", imem_addr, 32'h0000_0104);
        imem_valid = 1'b1;
        imem_rdata = mem(32'h0000_0104);
        br_taken   = 1'b1;
        br_target  = 32'hFFFF_FFFC;
        tick(0);
        fetch(32'hFFFF_FFFC, 1'b1);
        tick(1);
        chk("wrap_pc4", pc4_D, 32'd0);
        chk("wrap_addr", imem_addr, 32'd0);

        // flush wins over stall
        stall = 1'b1;
        flush = 1'b1;
        tick(0);
        stall = 1'b0;
        fetch(32'd0, 1'b1);
        tick(1);

        // reset asserted mid-HOLD
        imem_valid = 1'b1;
        imem_rdata = mem(32'd4);
        br_taken   = 1'b1;
        br_target  = 32'h0000_0040;
        tick(0);
        fetch(32'h0000_0040, 1'b0);
        stall = 1'b1;
        tick(0);
        chk("hold2_req", 32'(imem_req), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid_D), 32'd0);
        chk("midrst_instr", instr_D, NOP);
        chk("midrst_pc", pc_D, 32'd0);
        chk("midrst_pc4", pc4_D, 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd1);
        chk("midrst_addr", imem_addr, 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("midrst_fetch_cnt", fetch_cnt, 32'd0);
        chk("midrst_bubble_cnt", bubble_cnt, 32'd0);
`endif
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fetch(32'd0, 1'b1);
        tick(1);
`ifdef IF_PERF_CNT_EN
        chk("post_fetch_cnt", fetch_cnt, 32'd1);
        chk("post_bubble_cnt", bubble_cnt, 32'd0);
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 RESET_PC  32'h0000_0000  first fetch address after reset (parameter).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  fetch request; held with stable imem_addr until imem_valid.
REQ-005 imem_addr  output  32  fetch address, word aligned.
REQ-006 imem_valid  input  1  imem_rdata valid for current imem_addr; may assert in the request cycle (zero-wait) or later.
REQ-007 imem_rdata  input  32  fetched instruction.
REQ-008 stall  input  1  hold IF/ID contents (load-use hazard).
REQ-009 flush  input  1  replace IF/ID contents with a bubble.
REQ-010 br_taken  input  1  redirect from EX (branch, jal, jalr).
REQ-011 br_target  input  32  redirect address; bit 0 forced to 0.
REQ-012 instr_D, pc_D, pc4_D  output  32 each  IF/ID instruction, its PC, PC+4.
REQ-013 valid_D  output  1  IF/ID holds a real instruction.
REQ-014 opcode_D 7, func3_D 3, func7_5_D 1  outputs  instr_D[6:0], [14:12], [30]; feed the decoder directly.

Function
REQ-015 States: FETCH (request outstanding), HOLD (response buffered, stall active), DRAIN (discarding stale response after redirect).
REQ-016 FETCH: imem_req=1, imem_addr=PC; imem_valid & !stall -> IF/ID <= {rdata, PC, PC+4}, valid_D=1, PC <= PC+4, stay FETCH (one instruction per cycle with zero-wait memory).
REQ-017 FETCH, imem_valid & stall -> rdata and PC to hold buffer, IF/ID unchanged, go HOLD.
REQ-018 HOLD: imem_req=0; when stall drops, IF/ID <= buffer, PC <= PC+4, go FETCH.
REQ-019 FETCH, !imem_valid & !stall -> IF/ID <= bubble (instr_D=NOP 32'h0000_0013, valid_D=0); with stall, IF/ID holds.
REQ-020 flush or br_taken -> IF/ID <= bubble next edge; flush has priority over stall and over any load.
REQ-021 br_taken -> PC <= {br_target[31:1],1'b0}; buffered or same-cycle response discarded; from HOLD or FETCH with imem_valid go FETCH; FETCH without imem_valid go DRAIN.
REQ-022 DRAIN: imem_req=1 with old address; on imem_valid discard data, go FETCH at redirected PC; further br_taken in DRAIN updates PC only.
REQ-023 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); pc4_D likewise.
REQ-024 Fetch-to-IF/ID latency: one edge after imem_valid.

Reset
REQ-025 On rst: PC=RESET_PC, state FETCH, instr_D=NOP, pc_D=0, pc4_D=0, valid_D=0, hold buffer cleared; effective immediately, independent of clk.
REQ-026 Reset mid-transaction abandons the request; first post-reset request is RESET_PC.

Configuration
REQ-027 Macro IF_PERF_CNT_EN: defined -> outputs fetch_cnt (32, +1 per IF/ID load of valid instruction) and bubble_cnt (32, +1 per bubble inserted), both reset to 0, wrap at 2^32.
REQ-028 Undefined -> those ports and counters absent; all other behaviour identical.

Structure
REQ-029 Shared package rv_pkg holds NOP constant, fetch-state enum, default RESET_PC.
REQ-030 Sub-module if_id_reg (IF/ID register with stall/flush, bubble insertion) instantiated once; FSM, PC, hold buffer in if_stage.

Verification
REQ-031 Zero-wait memory, no hazards, RESET_PC=0 -> pc_D 0,4,8,... on consecutive cycles, valid_D=1 from second edge.
REQ-032 imem_valid 2 cycles late -> imem_addr stable throughout, one bubble (valid_D=0, instr_D=0x00000013) per wait cycle.
REQ-033 stall 3 cycles while response arrives -> HOLD, imem_req=0, IF/ID frozen; after release buffered instruction appears once, none lost or duplicated.
REQ-034 br_taken with br_target=0x101 during pending fetch -> DRAIN, stale response discarded, next imem_addr=0x100, IF/ID bubble.
REQ-035 PC=0xFFFF_FFFC fetch -> pc4_D=0, next imem_addr=0.
REQ-036 rst pulse mid-HOLD -> all outputs reset values immediately, next request RESET_PC; with IF_PERF_CNT_EN counters read 0.
